// File: rtl/breakout_scoreboard.sv
// Breakout score/lives keeper: hit-event FIFO, digit-serial BCD adder and game phase FSM.
// Define HISCORE_EN to add the show_hi input and a high-score register.
module breakout_scoreboard #(
  parameter int LIVES_INIT     = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int RESPAWN_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_start,
  input  logic       brick_hit,
  input  logic [2:0] brick_row,
  input  logic       ball_lost,
`ifdef HISCORE_EN
  input  logic       show_hi,
`endif
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic [2:0] lives,
  output logic [1:0] phase,
  output logic       busy,
  output logic       hit_drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RC_W  = $clog2(RESPAWN_CYCLES + 1);

  typedef enum logic [1:0] {
    PH_ATTRACT = 2'b00,
    PH_PLAY    = 2'b01,
    PH_RESPAWN = 2'b10,
    PH_OVER    = 2'b11
  } phase_e;

  typedef enum logic [2:0] {EN_IDLE, EN_POP, EN_D0, EN_D1, EN_D2, EN_D3} eng_e;

  phase_e           ph;
  eng_e             eng;
  logic [RC_W-1:0]  rcnt;
  logic [3:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [3:0]       operand;
  logic             carry;
  logic [3:0][3:0]  score;
  logic [15:0]      disp;

  logic       start_ok, push_req, push_ok, pop, lose_ok, fifo_full, fifo_empty;
  logic [1:0] dsel;
  logic [4:0] dsum;
  logic [3:0] dres;
  logic       dcarry;

  assign start_ok   = game_start && (ph == PH_ATTRACT || ph == PH_OVER);
  assign push_req   = brick_hit && ph == PH_PLAY;
  assign lose_ok    = ball_lost && ph == PH_PLAY;
  assign pop        = (eng == EN_POP);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok    = push_req && (!fifo_full || pop);

  // NOTE: payload storage has no reset; count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= 4'(brick_row) + 4'd1;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (start_ok) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: defaults first so no path through the block infers a latch.
  always_comb begin
    dsel = 2'd0;
    case (eng)
      EN_D1:   dsel = 2'd1;
      EN_D2:   dsel = 2'd2;
      EN_D3:   dsel = 2'd3;
      default: dsel = 2'd0;
    endcase
    dsum   = {1'b0, score[dsel]} + {4'b0, carry}
           + ((eng == EN_D0) ? {1'b0, operand} : 5'd0);
    dcarry = (dsum > 5'd9);
    dres   = dcarry ? 4'(dsum - 5'd10) : dsum[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng     <= EN_IDLE;
      operand <= '0;
      carry   <= 1'b0;
      score   <= '0;
    end else if (start_ok) begin
      eng     <= EN_IDLE;
      operand <= '0;
      carry   <= 1'b0;
      score   <= '0;
    end else begin
      case (eng)
        EN_IDLE: if (!fifo_empty) eng <= EN_POP;
        EN_POP: begin
          operand <= fifo_mem[rd_ptr];
          carry   <= 1'b0;
          eng     <= EN_D0;
        end
        EN_D0: begin score[0] <= dres; carry <= dcarry; eng <= EN_D1; end
        EN_D1: begin score[1] <= dres; carry <= dcarry; eng <= EN_D2; end
        EN_D2: begin score[2] <= dres; carry <= dcarry; eng <= EN_D3; end
        EN_D3: begin
          if (dcarry) score <= {4{4'd9}};
          else        score[3] <= dres;
          carry <= 1'b0;
          eng   <= fifo_empty ? EN_IDLE : EN_POP;
        end
        default: eng <= EN_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph       <= PH_ATTRACT;
      lives    <= '0;
      rcnt     <= '0;
      hit_drop <= 1'b0;
    end else if (start_ok) begin
      ph       <= PH_PLAY;
      lives    <= 3'(LIVES_INIT);
      rcnt     <= '0;
      hit_drop <= 1'b0;
    end else begin
      if (push_req && !push_ok) hit_drop <= 1'b1;
      case (ph)
        PH_PLAY: if (lose_ok) begin
          lives <= lives - 1'b1;
          ph    <= (lives == 3'd1) ? PH_OVER : PH_RESPAWN;
          rcnt  <= RC_W'(RESPAWN_CYCLES - 1);
        end
        PH_RESPAWN: begin
          if (rcnt == '0) ph <= PH_PLAY;
          else            rcnt <= rcnt - 1'b1;
        end
        default: ph <= ph;
      endcase
    end
  end

`ifdef HISCORE_EN
  logic [15:0] hiscore;
  logic        hi_pend;

  // Comparison waits for queued hits to drain; packed BCD orders like binary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiscore <= '0;
      hi_pend <= 1'b0;
    end else if (start_ok) begin
      hi_pend <= 1'b0;
    end else if (lose_ok && lives == 3'd1) begin
      hi_pend <= 1'b1;
    end else if (hi_pend && !busy) begin
      hi_pend <= 1'b0;
      if (score > hiscore) hiscore <= score;
    end
  end

  assign disp = show_hi ? hiscore : score;
`else
  assign disp = score;
`endif

  assign {digit3, digit2, digit1, digit0} = disp;
  assign phase = ph;
  assign busy  = (eng != EN_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_breakout_scoreboard.sv
// Scoreboard bench for breakout_scoreboard: expected scores queued per stimulus,
// compared by a monitor each time busy falls. Define HISCORE_EN to cover the high score.
module tb_breakout_scoreboard;

  localparam int RESPAWN = 20;

  logic       clk = 1'b0;
  logic       rst_n, game_start, brick_hit, ball_lost;
  logic [2:0] brick_row;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic [2:0] lives;
  logic [1:0] phase;
  logic       busy, hit_drop;
`ifdef HISCORE_EN
  logic       show_hi;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  int          model;
  logic        mon_en;

  always #5 clk = ~clk;

  breakout_scoreboard #(
    .LIVES_INIT(3), .FIFO_DEPTH(4), .RESPAWN_CYCLES(RESPAWN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .game_start(game_start), .brick_hit(brick_hit),
    .brick_row(brick_row), .ball_lost(ball_lost),
`ifdef HISCORE_EN
    .show_hi(show_hi),
`endif
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .lives(lives), .phase(phase), .busy(busy), .hit_drop(hit_drop)
  );

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] shown();
    return {digit3, digit2, digit1, digit0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    game_start = 1'b1;
    tick(1);
    game_start = 1'b0;
  endtask

  task automatic pulse_hit(input int row);
    brick_hit = 1'b1;
    brick_row = 3'(row);
    tick(1);
    brick_hit = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      tick(1);
      i++;
    end
    check("idle_in_budget", {31'b0, busy}, 32'd0);
    @(negedge clk);
    #1;
    check("results_pending", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic hit_drain(input int row);
    model = (model + row + 1 > 9999) ? 9999 : model + row + 1;
    exp_q.push_back(to_bcd(model));
    pulse_hit(row);
    wait_idle(12);
  endtask

  task automatic lose_ball(input int exp_lives, input int exp_phase);
    ball_lost = 1'b1;
    tick(1);
    ball_lost = 1'b0;
    check("lives_after_loss", {29'b0, lives}, exp_lives);
    check("phase_after_loss", {30'b0, phase}, exp_phase);
  endtask

  task automatic wait_respawn(input int exp_cycles);
    int n;
    n = 0;
    while (phase == 2'b10 && n < RESPAWN + 10) begin
      n++;
      tick(1);
    end
    check("respawn_exit_phase", {30'b0, phase}, 32'd1);
    if (exp_cycles >= 0) check("respawn_length", n, exp_cycles);
  endtask

  task automatic start_game();
    pulse_start();
    model = 0;
    check("start_phase", {30'b0, phase}, 32'd1);
    check("start_lives", {29'b0, lives}, 32'd3);
    check("start_score", {16'b0, shown()}, 32'd0);
    check("start_hit_drop", {31'b0, hit_drop}, 32'd0);
  endtask

  task automatic climb_to(input int target);
    while (model + 8 <= target) hit_drain(7);
    if (model < target) hit_drain(target - model - 1);
  endtask

`ifdef HISCORE_EN
  task automatic play_game(input int target);
    start_game();
    climb_to(target);
    lose_ball(2, 2);
    wait_respawn(RESPAWN);
    lose_ball(1, 2);
    wait_respawn(RESPAWN);
    lose_ball(0, 3);
    tick(2);
  endtask
`endif

  initial begin : monitor
    logic        prev_busy;
    logic [15:0] e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result got=%0h want=none t=%0t", shown(), $time);
        end else begin
          e = exp_q.pop_front();
          check("score", {16'b0, shown()}, {16'b0, e});
        end
      end
      prev_busy = busy;
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; game_start = 1'b0; brick_hit = 1'b0; brick_row = '0;
    ball_lost = 1'b0; mon_en = 1'b0; model = 0;
`ifdef HISCORE_EN
    show_hi = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #10;
    check("rst_score", {16'b0, shown()}, 32'd0);
    check("rst_lives", {29'b0, lives}, 32'd0);
    check("rst_phase", {30'b0, phase}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hit_drop", {31'b0, hit_drop}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);
    start_game();

    // Reset asserted while an add is in flight clears everything at once.
    pulse_hit(3);
    tick(2);
    check("mid_add_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_score", {16'b0, shown()}, 32'd0);
    check("async_rst_lives", {29'b0, lives}, 32'd0);
    check("async_rst_phase", {30'b0, phase}, 32'd0);
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    #3 rst_n = 1'b1;
    tick(2);
    mon_en = 1'b1;
    start_game();

    // Three back-to-back hits: 1 + 5 + 8 = 14.
    model = 14;
    exp_q.push_back(to_bcd(14));
    pulse_hit(0);
    pulse_hit(4);
    pulse_hit(7);
    wait_idle(15);

    // Six consecutive hits worth 1..6: the sixth finds the FIFO full.
    model = 14 + 15;
    exp_q.push_back(to_bcd(model));
    for (int r = 0; r < 6; r++) pulse_hit(r);
    wait_idle(40);
    check("hit_drop_set", {31'b0, hit_drop}, 32'd1);

    climb_to(9995);
    check("score_9995", {16'b0, shown()}, {16'b0, to_bcd(9995)});
    hit_drain(7);
    hit_drain(7);
    check("score_saturated", {16'b0, shown()}, {16'b0, to_bcd(9999)});
    check("hit_drop_sticky", {31'b0, hit_drop}, 32'd1);

    lose_ball(2, 2);
    wait_respawn(RESPAWN);
    lose_ball(1, 2);
    wait_respawn(RESPAWN);
    lose_ball(0, 3);

    // Events in OVER are ignored.
    lose_ball(0, 3);
    pulse_hit(7);
    check("over_hit_ignored", {31'b0, busy}, 32'd0);

    start_game();
    lose_ball(2, 2);
    pulse_hit(2);
    check("respawn_hit_busy", {31'b0, busy}, 32'd0);
    check("respawn_hit_score", {16'b0, shown()}, 32'd0);
    pulse_start();
    check("respawn_start_lives", {29'b0, lives}, 32'd2);
    check("respawn_start_phase", {30'b0, phase}, 32'd2);
    wait_respawn(RESPAWN - 2);

    // Hit and loss in the same cycle: hit queued, then drained during RESPAWN.
    model = 2;
    exp_q.push_back(to_bcd(2));
    brick_hit = 1'b1;
    brick_row = 3'd1;
    ball_lost = 1'b1;
    tick(1);
    brick_hit = 1'b0;
    ball_lost = 1'b0;
    check("simul_lives", {29'b0, lives}, 32'd1);
    check("simul_phase", {30'b0, phase}, 32'd2);
    wait_idle(12);
    wait_respawn(-1);

`ifdef HISCORE_EN
    lose_ball(0, 3);
    tick(2);
    play_game(42);
    show_hi = 1'b1;
    #1 check("hi_after_42", {16'b0, shown()}, {16'b0, to_bcd(42)});
    show_hi = 1'b0;
    play_game(17);
    show_hi = 1'b1;
    #1 check("hi_kept_42", {16'b0, shown()}, {16'b0, to_bcd(42)});
    show_hi = 1'b0;
    #1 check("score_17", {16'b0, shown()}, {16'b0, to_bcd(17)});
    play_game(100);
    show_hi = 1'b1;
    #1 check("hi_after_100", {16'b0, shown()}, {16'b0, to_bcd(100)});
    show_hi = 1'b0;
`endif

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
